div_seq: RTL and testbench

//  Sequential restoring shift-and-subtract divider; the inverse of the shift-and-add

---
 rtl/div_seq_if.sv | 25 ++
 rtl/div_seq.sv | 113 +++++++++++
 tb/tb_div_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master side issues requests. The slave side (div_seq) returns results.
interface div_seq_if #(
   parameter int N = 16,
   parameter int M = 8
);
   logic         start;
   logic [N-1:0] dividendo;
   logic [M-1:0] divisor;
   logic [N-1:0] quociente;
   logic [M-1:0] resto;
   logic         ocupado;
   logic         pronto;
   logic         erro;

   modport master (
      output start, dividendo, divisor,
      input  quociente, resto, ocupado, pronto, erro
   );

   modport slave (
      input  start, dividendo, divisor,
      output quociente, resto, ocupado, pronto, erro
   );
endinterface

// File: rtl/div_seq.sv
// Unsigned restoring shift-and-subtract divider that produces one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and returns all-ones / dividend-low-bits with erro set.
module div_seq #(
   parameter int N = 16,
   parameter int M = 8
) (
   input  logic     clock,
   input  logic     reset_n,
   div_seq_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [M-1:0]  r;
   logic [M-1:0]  d;
   logic [N-1:0]  q;
   logic [N-1:0]  quo;
   logic [M-1:0]  rem;
   logic          err;

   logic [M:0]    r_sh;
   logic          ge;
   logic [M-1:0]  r_nx;
   logic [N-1:0]  q_nx;
   logic          accept;
   logic          last;
   logic          busy;
   logic          done;

   // r holds only M bits: the partial remainder stays below d, so the
   // (M+1)-bit value exists only transiently as r_sh.
   always_comb begin
      r_sh = {r, q[N-1]};
      ge   = r_sh >= {1'b0, d};
      r_nx = ge ? M'(r_sh - {1'b0, d}) : r_sh[M-1:0];
      q_nx = {q[N-2:0], ge};
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = (bus.divisor == '0) ? DONE : RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CW'(1)) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         r   <= '0;
         q   <= '0;
         d   <= '0;
         quo <= '0;
         rem <= '0;
         err <= 1'b0;
      end else if (accept) begin
         d   <= bus.divisor;
         q   <= bus.dividendo;
         r   <= '0;
         cnt <= CW'(N);
         if (bus.divisor == '0) begin
            quo <= '1;
            rem <= bus.dividendo[M-1:0];
            err <= 1'b1;
         end
      end else if (state == RUN) begin
         q   <= q_nx;
         r   <= r_nx;
         cnt <= cnt - CW'(1);
         if (last) begin
            quo <= q_nx;
            rem <= r_nx;
            err <= 1'b0;
         end
      end
   end

   assign bus.quociente = quo;
   assign bus.resto     = rem;
   assign bus.erro      = err;
   assign bus.ocupado   = busy;
   assign bus.pronto    = done;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (N=16, M=8). It checks results, latency, busy time, the pronto pulse width,
// back-to-back operation and mid-operation reset. A short random sweep is checked against integer / and %.
module tb_div_seq;
   localparam int N = 16;
   localparam int M = 8;

   logic clock;
   logic reset_n;
   int   tests;
   int   fails;

   div_seq_if #(.N(N), .M(M)) bus ();

   div_seq #(.N(N), .M(M)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Waits at most 40 edges for pronto. lat counts the start edge as 1.
   task automatic wait_pronto(output int lat, output int busy);
      lat  = 1;
      busy = 0;
      while (!bus.pronto && lat < 40) begin
         if (bus.ocupado) busy++;
         tick();
         lat++;
      end
   endtask

   task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic ee);
      int lat, busy;
      bus.dividendo = a;
      bus.divisor   = b;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.dividendo = 16'(~a);
      bus.divisor   = 8'(b + 8'd1);
      wait_pronto(lat, busy);
      chk({tag, "_lat"}, lat, (b == 8'd0) ? 1 : N + 1);
      chk({tag, "_busy"}, busy, (b == 8'd0) ? 0 : N);
      chk({tag, "_q"}, bus.quociente, eq);
      chk({tag, "_r"}, bus.resto, er);
      chk({tag, "_e"}, bus.erro, ee);
      chk({tag, "_ocup_at_done"}, bus.ocupado, 0);
      tick();
      chk({tag, "_pronto_width"}, bus.pronto, 0);
      chk({tag, "_q_hold"}, bus.quociente, eq);
   endtask

   initial begin
      int lat, busy;
      bit saw;
      logic [15:0] a;
      logic [7:0]  b;
      tests = 0;
      fails = 0;
      bus.start     = 1'b0;
      bus.dividendo = '0;
      bus.divisor   = '0;
      reset_n       = 1'b0;
      #12;
      chk("rst_q", bus.quociente, 0);
      chk("rst_r", bus.resto, 0);
      chk("rst_ocup", bus.ocupado, 0);
      chk("rst_pronto", bus.pronto, 0);
      chk("rst_erro", bus.erro, 0);
      reset_n = 1'b1;
      tick();
      tick();

      run_div("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
      run_div("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
      run_div("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
      run_div("d0_5", 16'd0, 8'd5, 16'd0, 8'd0, 1'b0);
      run_div("d6_200", 16'd6, 8'd200, 16'd0, 8'd6, 1'b0);
      run_div("d100_0", 16'd100, 8'd0, 16'hFFFF, 8'd100, 1'b1);
      run_div("d9_3", 16'd9, 8'd3, 16'd3, 8'd0, 1'b0);
      run_div("d300_0", 16'h012C, 8'd0, 16'hFFFF, 8'h2C, 1'b1);
      run_div("d255_255", 16'd255, 8'd255, 16'd1, 8'd0, 1'b0);

      // Back-to-back: start held high, new operands appear only in the DONE cycle
      bus.dividendo = 16'd1000;
      bus.divisor   = 8'd7;
      bus.start     = 1'b1;
      tick();
      bus.dividendo = 16'd5;
      bus.divisor   = 8'd1;
      wait_pronto(lat, busy);
      chk("b2b1_lat", lat, N + 1);
      chk("b2b1_q", bus.quociente, 142);
      chk("b2b1_r", bus.resto, 6);
      bus.dividendo = 16'd50;
      bus.divisor   = 8'd8;
      tick();
      chk("b2b_no_gap", bus.ocupado, 1);
      chk("b2b_q_held", bus.quociente, 142);
      bus.start     = 1'b0;
      bus.dividendo = 16'd0;
      bus.divisor   = 8'd0;
      wait_pronto(lat, busy);
      chk("b2b2_lat", lat, N + 1);
      chk("b2b2_q", bus.quociente, 6);
      chk("b2b2_r", bus.resto, 2);
      chk("b2b2_e", bus.erro, 0);
      tick();
      chk("b2b2_pronto_width", bus.pronto, 0);

      // Mid-operation reset after a zero divide, so every output starts nonzero
      run_div("pre_rst", 16'd100, 8'd0, 16'hFFFF, 8'd100, 1'b1);
      bus.dividendo = 16'd1000;
      bus.divisor   = 8'd7;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      reset_n = 1'b0;
      #1;
      chk("mrst_q", bus.quociente, 0);
      chk("mrst_r", bus.resto, 0);
      chk("mrst_e", bus.erro, 0);
      chk("mrst_ocup", bus.ocupado, 0);
      chk("mrst_pronto", bus.pronto, 0);
      #3;
      reset_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.pronto) saw = 1'b1;
      end
      chk("mrst_no_pronto", saw, 0);
      run_div("post_rst", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);

      for (int i = 0; i < 300; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         if (b == 8'd0) run_div("rnd", a, b, 16'hFFFF, a[7:0], 1'b1);
         else           run_div("rnd", a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
